// File: rtl/pwl_mix_pkg.sv
// Shared sizing, mixer FSM states and the saturating clamp used by the output mixer.
package pwl_mix_pkg;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 10;
  localparam int ACC_W    = 12;
  localparam int OUT_W    = 8;
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int GAIN_W   = ACC_W + 3;

  typedef enum logic {ACCUM = 1'b0, COMMIT = 1'b1} mix_state_t;

  typedef struct packed {
    logic             clipped;
    logic [ACC_W-1:0] val;
  } clip_t;

  // In range exactly when every bit above the ACC_W sign bit matches it.
  function automatic clip_t clamp(input logic signed [GAIN_W-1:0] g);
    clip_t r;
    r.clipped = (g[GAIN_W-1:ACC_W-1] != {(GAIN_W-ACC_W+1){g[GAIN_W-1]}});
    if (!r.clipped)
      r.val = g[ACC_W-1:0];
    else if (g[GAIN_W-1])
      r.val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      r.val = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction
endpackage

// File: rtl/pwl_pwm_dac.sv
// 1-bit audio DAC: period-aligned PWM or first-order sigma-delta from an unsigned sample.
module pwl_pwm_dac
  import pwl_mix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [OUT_W-1:0] i_sample,
  output logic             o_pwm_out
);
  logic [OUT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_duty;
  logic [OUT_W-1:0] r_err;
  logic             r_mode_q;
  logic             r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_duty   <= 8'h80;
      r_err    <= '0;
      r_mode_q <= 1'b0;
      r_pwm    <= 1'b0;
    end else begin
      r_mode_q <= i_mode;
      if (!i_en) begin
        r_cnt  <= '0;
        r_err  <= '0;
        r_duty <= i_sample;
        r_pwm  <= 1'b0;
      end else if (i_mode != r_mode_q) begin
        r_cnt <= '0;
        r_err <= '0;
        r_pwm <= 1'b0;
      end else if (!i_mode) begin
        r_cnt <= r_cnt + 1'b1;
        // Duty only reloads on the last count, so a period is never split.
        if (r_cnt == {OUT_W{1'b1}}) r_duty <= i_sample;
        r_pwm <= (r_cnt < r_duty);
      end else begin
        {r_pwm, r_err} <= {1'b0, r_err} + {1'b0, i_sample};
      end
    end
  end

  assign o_pwm_out = r_pwm;
endmodule

// File: rtl/pwl_output_mixer.sv
// Frame mixer: sums per-channel beats, applies master gain with clipping, feeds the 1-bit DAC.
module pwl_output_mixer
  import pwl_mix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [CH_W-1:0]     i_in_chan,
  input  logic [SAMPLE_W-1:0] i_in_sample,
  input  logic                i_in_last,
  input  logic [NUM_CH-1:0]   i_ch_mute,
  input  logic [1:0]          i_gain,
  input  logic                i_mode,
  input  logic                i_clr_overflow,
  output logic [OUT_W-1:0]    o_sample_out,
  output logic                o_frame_strobe,
  output logic                o_overflow,
  output logic                o_pwm_out
);
  mix_state_t              r_state, w_next;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_add;
  logic signed [GAIN_W-1:0] w_gained;
  clip_t                   w_clip;
  logic                    w_fire;
  logic                    w_unused_lsb;
  logic [OUT_W-1:0]        r_sample_out;
  logic                    r_strobe;
  logic                    r_overflow;

  assign o_in_ready = (r_state == ACCUM);
  assign w_fire     = i_in_valid && o_in_ready;
  assign w_add      = i_ch_mute[i_in_chan] ? '0 :
                      {{(ACC_W-SAMPLE_W){i_in_sample[SAMPLE_W-1]}}, i_in_sample};
  assign w_gained   = {{(GAIN_W-ACC_W){r_acc[ACC_W-1]}}, r_acc} <<< i_gain;
  assign w_clip     = clamp(w_gained);
  assign w_unused_lsb = ^w_clip.val[ACC_W-OUT_W-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (w_fire && i_in_last) w_next = COMMIT;
      COMMIT:  w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACCUM;
      r_acc        <= '0;
      r_sample_out <= 8'h80;
      r_strobe     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_strobe <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_acc        <= '0;
        // Offset binary: flip the sign bit so silence sits at mid-scale.
        r_sample_out <= {~w_clip.val[ACC_W-1], w_clip.val[ACC_W-2 -: OUT_W-1]};
      end else if (w_fire) begin
        r_acc <= r_acc + w_add;
      end
      if ((r_state == COMMIT) && w_clip.clipped) r_overflow <= 1'b1;
      else if (i_clr_overflow)                   r_overflow <= 1'b0;
    end
  end

  assign o_sample_out   = r_sample_out;
  assign o_frame_strobe = r_strobe;
  assign o_overflow     = r_overflow;

  pwl_pwm_dac u_dac (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_en),
    .i_mode   (i_mode),
    .i_sample (r_sample_out),
    .o_pwm_out(o_pwm_out)
  );
endmodule
